// File: rtl/crc24_append_if.sv
// Serial bit-stream bus between the packet source, the CRC24 appender and the whitening stage.
interface crc24_append_if #(
  parameter int W = 24
);
  logic [W-1:0] crc_state_init_bit;
  logic         crc_state_init_bit_load;
  logic         data_in;
  logic         data_in_valid;
  logic         data_in_valid_last;
  logic         data_in_ready;
  logic         data_out;
  logic         data_out_valid;
  logic         data_out_valid_last;

  modport master (
    output crc_state_init_bit, crc_state_init_bit_load,
    output data_in, data_in_valid, data_in_valid_last,
    input  data_in_ready,
    input  data_out, data_out_valid, data_out_valid_last
  );

  modport slave (
    input  crc_state_init_bit, crc_state_init_bit_load,
    input  data_in, data_in_valid, data_in_valid_last,
    output data_in_ready,
    output data_out, data_out_valid, data_out_valid_last
  );
endinterface

// File: rtl/crc24_append.sv
// BLE TX: passes the serial packet through with one cycle of latency and appends CRC24 over the PDU.
module crc24_append #(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int HEADER_BIT_LEN      = 40
) (
  input  logic         clk,
  input  logic         rst,
  crc24_append_if.slave bus
);
  localparam int CW = CRC_STATE_BIT_WIDTH;
  // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1; the x^24 term is the feedback itself
  localparam logic [CW-1:0] POLY = CW'(24'h00065B);

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PDU     = 2'd1,
    CRC_OUT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    data_in_count_q, data_in_count_d;
  logic [4:0]    crc_out_count_q, crc_out_count_d;
  logic [CW-1:0] lfsr_q, lfsr_d;
  logic          data_out_q, data_out_d;
  logic          data_out_valid_q, data_out_valid_d;
  logic          data_out_valid_last_q, data_out_valid_last_d;

  logic          accept;
  logic          fb;
  logic [CW-1:0] lfsr_step;
  logic [8:0]    count_inc;

  assign bus.data_in_ready       = (state_q != CRC_OUT);
  assign bus.data_out            = data_out_q;
  assign bus.data_out_valid      = data_out_valid_q;
  assign bus.data_out_valid_last = data_out_valid_last_q;

  assign accept    = bus.data_in_valid && (state_q != CRC_OUT);
  assign fb        = bus.data_in ^ lfsr_q[CW-1];
  assign lfsr_step = {lfsr_q[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign count_inc = data_in_count_q + 9'd1;

  always_comb begin
    state_d               = state_q;
    data_in_count_d       = data_in_count_q;
    crc_out_count_d       = crc_out_count_q;
    lfsr_d                = lfsr_q;
    data_out_d            = data_out_q;
    data_out_valid_d      = 1'b0;
    data_out_valid_last_d = 1'b0;

    unique case (state_q)
      HEADER: begin
        if (accept) begin
          data_out_d       = bus.data_in;
          data_out_valid_d = 1'b1;
          if (bus.data_in_valid_last) begin
            // aborted packet: flag passes through, nothing appended
            data_out_valid_last_d = 1'b1;
            data_in_count_d       = '0;
          end else begin
            data_in_count_d = count_inc;
            if (count_inc == 9'(HEADER_BIT_LEN)) state_d = PDU;
          end
        end
        if (bus.crc_state_init_bit_load) lfsr_d = bus.crc_state_init_bit;
      end

      PDU: begin
        if (accept) begin
          data_out_d       = bus.data_in;
          data_out_valid_d = 1'b1;
          data_in_count_d  = count_inc;
          lfsr_d           = lfsr_step;
          if (bus.data_in_valid_last) begin
            state_d         = CRC_OUT;
            crc_out_count_d = '0;
          end
        end
        if (bus.crc_state_init_bit_load) lfsr_d = bus.crc_state_init_bit;
      end

      CRC_OUT: begin
        data_out_d       = lfsr_q[CW-1];
        data_out_valid_d = 1'b1;
        lfsr_d           = {lfsr_q[CW-2:0], 1'b0};
        crc_out_count_d  = crc_out_count_q + 5'd1;
        if (crc_out_count_q == 5'(CW-1)) begin
          data_out_valid_last_d = 1'b1;
          data_in_count_d       = '0;
          crc_out_count_d       = '0;
          state_d               = HEADER;
        end
      end

      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= HEADER;
      data_in_count_q       <= '0;
      crc_out_count_q       <= '0;
      lfsr_q                <= '0;
      data_out_q            <= 1'b0;
      data_out_valid_q      <= 1'b0;
      data_out_valid_last_q <= 1'b0;
    end else begin
      state_q               <= state_d;
      data_in_count_q       <= data_in_count_d;
      crc_out_count_q       <= crc_out_count_d;
      lfsr_q                <= lfsr_d;
      data_out_q            <= data_out_d;
      data_out_valid_q      <= data_out_valid_d;
      data_out_valid_last_q <= data_out_valid_last_d;
    end
  end
endmodule

// File: tb/tb_crc24_append.sv
// Scoreboard bench for crc24_append: expected bits with their exact output cycle are queued at drive time.
module tb_crc24_append;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crc24_append_if #(.W(24)) bus ();
  crc24_append #(.CRC_STATE_BIT_WIDTH(24), .HEADER_BIT_LEN(40)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int unsigned cyc;
    logic        b;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic        tx_bits[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc_cnt = 0;
  int unsigned out_cnt = 0;
  logic [23:0] crc_cap = '0;
  int          first_wait;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // golden model written from the tap list of the BLE polynomial
  function automatic logic [23:0] crc_model(input logic [23:0] c, input logic b);
    logic        n;
    logic [23:0] r;
    n = b ^ c[23];
    r[0] = n;
    for (int i = 1; i < 24; i++) begin
      if (i == 1 || i == 3 || i == 4 || i == 6 || i == 9 || i == 10) r[i] = c[i-1] ^ n;
      else r[i] = c[i-1];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.data_out_valid) begin
      out_cnt++;
      crc_cap = {crc_cap[22:0], bus.data_out};
      if (sb.size() == 0) chk("spurious_out", 32'(bus.data_out_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_cycle", cyc_cnt, e.cyc);
        chk("out_bit", 32'(bus.data_out), 32'(e.b));
        chk("out_last", 32'(bus.data_out_valid_last), 32'(e.l));
      end
    end else if (!rst && bus.data_out_valid_last) begin
      chk("last_wo_valid", 32'(bus.data_out_valid_last), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_init(input logic [23:0] v);
    bus.crc_state_init_bit      = v;
    bus.crc_state_init_bit_load = 1'b1;
    tick();
    bus.crc_state_init_bit_load = 1'b0;
  endtask

  task automatic build(input int n_hdr, input int n_pdu, input int mode);
    tx_bits.delete();
    for (int i = 0; i < n_hdr; i++)
      tx_bits.push_back(mode == 1 ? logic'(i % 2) : logic'($urandom_range(0, 1)));
    for (int i = 0; i < n_pdu; i++)
      tx_bits.push_back(mode == 2 ? 1'b0 : (mode == 3 ? 1'b1 : logic'($urandom_range(0, 1))));
  endtask

  // Drives tx_bits, holding each bit offered until accepted; returns one cycle after the last bit.
  task automatic send(input logic [23:0] init, input bit abort, input int gap_pct, input bit ld_first);
    logic [23:0] c;
    int unsigned t_last;
    int          w;
    c = init;
    t_last = 0;
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (i > 0 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.data_in_valid = 1'b0;
        tick();
      end
      bus.data_in            = tx_bits[i];
      bus.data_in_valid      = 1'b1;
      bus.data_in_valid_last = (i == tx_bits.size() - 1);
      if (i == 0 && ld_first) begin
        bus.crc_state_init_bit      = init;
        bus.crc_state_init_bit_load = 1'b1;
      end
      w = 0;
      while (!bus.data_in_ready && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) chk("ready_timeout", 32'(w), 32'd0);
      if (i == 0) first_wait = w;
      sb.push_back('{cyc: cyc_cnt + 1, b: tx_bits[i],
                     l: (abort && i == tx_bits.size() - 1)});
      if (i >= 40) c = crc_model(c, tx_bits[i]);
      t_last = cyc_cnt;
      tick();
      bus.crc_state_init_bit_load = 1'b0;
    end
    bus.data_in_valid      = 1'b0;
    bus.data_in_valid_last = 1'b0;
    if (!abort)
      for (int k = 0; k < 24; k++)
        sb.push_back('{cyc: t_last + 2 + k, b: c[23-k], l: (k == 23)});
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      tick();
      w++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    int unsigned oc;
    bus.crc_state_init_bit      = '0;
    bus.crc_state_init_bit_load = 1'b0;
    bus.data_in                 = 1'b0;
    bus.data_in_valid           = 1'b0;
    bus.data_in_valid_last      = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
    chk("rst_last", 32'(bus.data_out_valid_last), 32'd0);
    chk("rst_ready", 32'(bus.data_in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // header 0xAA.. pass-through with a 1-bit PDU
    load_init(24'h123456);
    build(40, 1, 1);
    send(24'h123456, 1'b0, 0, 1'b0);
    drain();

    // all-zero PDU with zero init: 40 + 16 + 24 outputs, all-zero CRC
    load_init(24'h000000);
    build(40, 16, 2);
    oc = out_cnt;
    send(24'h000000, 1'b0, 0, 1'b0);
    drain();
    chk("zero_out_count", out_cnt - oc, 32'd80);
    chk("zero_crc", 32'(crc_cap), 32'h000000);

    // single '1' PDU bit
    load_init(24'h000000);
    build(40, 1, 3);
    send(24'h000000, 1'b0, 0, 1'b0);
    drain();
    chk("one_bit_crc", 32'(crc_cap), 32'h00065B);

    // back-to-back: second packet offered (with its init load) while CRC is still emitted
    load_init(24'h555555);
    build(40, 37, 0);
    send(24'h555555, 1'b0, 0, 1'b0);
    build(40, 29, 0);
    send(24'h555555, 1'b0, 0, 1'b1);
    chk("b2b_ready_low_cycles", 32'(first_wait), 32'd24);
    drain();

    // reset while CRC bit 10 is on the output
    load_init(24'hABCDEF);
    build(40, 20, 0);
    send(24'hABCDEF, 1'b0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.data_out_valid), 32'd0);
    chk("mid_rst_last", 32'(bus.data_out_valid_last), 32'd0);
    chk("mid_rst_ready", 32'(bus.data_in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    load_init(24'h0F0F0F);
    build(40, 33, 0);
    send(24'h0F0F0F, 1'b0, 30, 1'b0);
    drain();

    // abort on header bit 20, then a packet using the untouched LFSR and cleared count
    load_init(24'h314159);
    build(20, 0, 0);
    send(24'h314159, 1'b1, 0, 1'b0);
    build(40, 24, 0);
    send(24'h314159, 1'b0, 0, 1'b0);
    drain();

    // random packets with idle gaps
    for (int p = 0; p < 4; p++) begin
      logic [23:0] iv;
      iv = 24'($urandom());
      load_init(iv);
      build(40, $urandom_range(1, 60), 0);
      send(iv, 1'b0, 25, 1'b0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
